taxi_meter_ctrl: RTL

//  Consumes the three debounced key levels (stop, add_km, change_dis) from the key stage.

---
 rtl/taxi_meter_if.sv | 22 ++
 rtl/taxi_meter_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/taxi_meter_if.sv
// Key levels into the taxi meter controller and its trip/display values out.
interface taxi_meter_if;
  logic        stop;
  logic        add_km;
  logic        change_dis;
  logic [1:0]  state;
  logic [15:0] fare;
  logic [9:0]  km;
  logic [11:0] wait_sec;
  logic [1:0]  disp_sel;
  logic [15:0] disp_val;

  modport master (
    output stop, add_km, change_dis,
    input  state, fare, km, wait_sec, disp_sel, disp_val
  );

  modport slave (
    input  stop, add_km, change_dis,
    output state, fare, km, wait_sec, disp_sel, disp_val
  );
endinterface

// File: rtl/taxi_meter_ctrl.sv
// Taxi meter trip controller: key edge detection, trip FSM, saturating distance/wait/fare
// accumulation and display selection.
module taxi_meter_ctrl #(
  parameter int unsigned TICK_CYCLES   = 50_000_000,
  parameter int unsigned BASE_FARE     = 100,
  parameter int unsigned BASE_KM       = 3,
  parameter int unsigned PER_KM        = 20,
  parameter int unsigned WAIT_UNIT_SEC = 60,
  parameter int unsigned PER_WAIT      = 10
) (
  input  logic         clk,
  input  logic         reset,
  taxi_meter_if.slave  bus
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned UW = $clog2(WAIT_UNIT_SEC + 1);
  localparam logic [9:0]  KmMax   = 10'd999;
  localparam logic [11:0] WaitMax = 12'hFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e        state_q;
  logic [15:0]   fare_q;
  logic [9:0]    km_q;
  logic [11:0]   wait_q;
  logic [1:0]    disp_sel_q;
  logic [PW-1:0] presc_q;
  logic [UW-1:0] unit_q;
  logic          stop_prev_q, add_prev_q, chg_prev_q;

  logic        ev_stop, ev_add, ev_chg;
  logic        tick, unit_done;
  logic        km_inc, km_charge;
  logic [9:0]  km_plus;
  logic [17:0] fare_sum;
  logic [15:0] fare_next;

  always_comb begin
    ev_stop   = bus.stop & ~stop_prev_q;
    ev_add    = bus.add_km & ~add_prev_q;
    ev_chg    = bus.change_dis & ~chg_prev_q;
    tick      = (state_q == StWait) && (presc_q == PW'(TICK_CYCLES - 1));
    unit_done = tick && (unit_q == UW'(WAIT_UNIT_SEC - 1));
    km_plus   = km_q + 10'd1;
    // In WAIT a simultaneous stop takes priority and the km press is dropped.
    km_inc    = ev_add && (km_q != KmMax) &&
                ((state_q == StRun) || ((state_q == StWait) && !ev_stop));
    km_charge = km_inc && (32'(km_plus) > BASE_KM);
    fare_sum  = 18'(fare_q) + (km_charge ? 18'(PER_KM) : 18'd0)
                + (unit_done ? 18'(PER_WAIT) : 18'd0);
    fare_next = (fare_sum > 18'h0FFFF) ? 16'hFFFF : fare_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      fare_q      <= '0;
      km_q        <= '0;
      wait_q      <= '0;
      disp_sel_q  <= '0;
      presc_q     <= '0;
      unit_q      <= '0;
      // Keys held through reset must not produce an event on release.
      stop_prev_q <= 1'b1;
      add_prev_q  <= 1'b1;
      chg_prev_q  <= 1'b1;
    end else begin
      stop_prev_q <= bus.stop;
      add_prev_q  <= bus.add_km;
      chg_prev_q  <= bus.change_dis;

      if (ev_chg) begin
        disp_sel_q <= (disp_sel_q == 2'd2) ? 2'd0 : disp_sel_q + 2'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (ev_stop) begin
            state_q <= StRun;
            fare_q  <= 16'(BASE_FARE);
            km_q    <= '0;
            wait_q  <= '0;
            presc_q <= '0;
            unit_q  <= '0;
          end
        end
        StRun: begin
          if (km_inc) km_q <= km_plus;
          fare_q <= fare_next;
          if (ev_stop) begin
            state_q <= StWait;
            presc_q <= '0;
          end
        end
        StWait: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (wait_q != WaitMax) wait_q <= wait_q + 12'd1;
            unit_q <= unit_done ? '0 : unit_q + UW'(1);
          end
          if (km_inc) km_q <= km_plus;
          fare_q <= fare_next;
          if (ev_stop) begin
            state_q <= StDone;
          end else if (ev_add) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          if (ev_stop) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    unique case (disp_sel_q)
      2'd0:    bus.disp_val = fare_q;
      2'd1:    bus.disp_val = {6'd0, km_q};
      2'd2:    bus.disp_val = {4'd0, wait_q};
      default: bus.disp_val = '0;
    endcase
  end

  assign bus.state    = state_q;
  assign bus.fare     = fare_q;
  assign bus.km       = km_q;
  assign bus.wait_sec = wait_q;
  assign bus.disp_sel = disp_sel_q;

endmodule
